// File: rtl/mem_loader.sv
// mem_loader: byte-stream memory loader.
//
// Parses framed load records from a byte source and writes their payload into
// RAM through a single-cycle write port. The record format is:
//   0x55, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes [, CSUM]
//
// Build option: define MEM_LOADER_CHECKSUM_EN to require and verify the CSUM
// trailer byte. The modulo-256 sum of every byte after 0x55 (trailer
// included) must be 0x00. Without the macro, a record ends after its last
// data byte, and the only error source is a timeout.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   byte present on in_data
//   in_data   in   stream byte
//   in_ready  out  byte accepted when in_valid & in_ready (equals ~rst)
//   wr_en     out  one-cycle RAM write strobe (registered)
//   wr_addr   out  write address (registered, holds when idle)
//   wr_data   out  write data (registered, holds when idle)
//   busy      out  high whenever a record is in progress
//   done      out  one-cycle pulse on successful record completion
//   error     out  one-cycle pulse on checksum mismatch or timeout
module mem_loader #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // The gap counter only needs to reach TIMEOUT_CYCLES-1.
    // The timeout fires on the idle cycle that would take it to TIMEOUT_CYCLES.
    localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_H = 3'd1,
        S_ADDR_L = 3'd2,
        S_LEN_H  = 3'd3,
        S_LEN_L  = 3'd4,
`ifdef MEM_LOADER_CHECKSUM_EN
        S_DATA   = 3'd5,
        S_CSUM   = 3'd6
`else
        S_DATA   = 3'd5
`endif
    } state_t;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic   CSUM_EN = 1'b1;
    localparam state_t S_END   = S_CSUM;
`else
    localparam logic   CSUM_EN = 1'b0;
    localparam state_t S_END   = S_IDLE;
`endif

    state_t                state_r;
    state_t                state_s;
    logic [7:0]            addr_h_r;
    logic [7:0]            len_h_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [15:0]           rem_r;
    logic [GAP_W-1:0]      gap_r;
    logic                  accept_s;
    logic                  timeout_s;
    logic                  zero_len_s;
    logic                  last_data_s;
    logic                  wr_en_s;
    logic                  done_s;
    logic                  error_s;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_r;
    logic                  csum_ok_s;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    assign csum_ok_s = (csum_add(csum_r, in_data) == 8'h00);
`endif

    assign in_ready    = ~rst;
    assign accept_s    = in_valid & ~rst;
    assign zero_len_s  = ({len_h_r, in_data} == 16'd0);
    assign last_data_s = (rem_r == 16'd1);
    assign timeout_s   = (state_r != S_IDLE) && !accept_s && (gap_r == GAP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: advance on each accepted byte, abort on timeout
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = S_IDLE;
        end else if (accept_s) begin
            case (state_r)
                S_IDLE:   state_s = (in_data == 8'h55) ? S_ADDR_H : S_IDLE;
                S_ADDR_H: state_s = S_ADDR_L;
                S_ADDR_L: state_s = S_LEN_H;
                S_LEN_H:  state_s = S_LEN_L;
                S_LEN_L:  state_s = zero_len_s ? S_END : S_DATA;
                S_DATA:   state_s = last_data_s ? S_END : S_DATA;
                default:  state_s = S_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode: next values for the registered strobes
    always_comb begin
        wr_en_s = 1'b0;
        done_s  = 1'b0;
        error_s = 1'b0;
        if (timeout_s) begin
            error_s = 1'b1;
        end else if (accept_s) begin
            case (state_r)
                S_LEN_L: done_s = zero_len_s & ~CSUM_EN;
                S_DATA: begin
                    wr_en_s = 1'b1;
                    done_s  = last_data_s & ~CSUM_EN;
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    done_s  = csum_ok_s;
                    error_s = ~csum_ok_s;
                end
`endif
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Registered outputs, header capture, address/count and gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            addr_h_r <= 8'h00;
            len_h_r  <= 8'h00;
            addr_r   <= '0;
            rem_r    <= 16'd0;
            gap_r    <= '0;
        end else begin
            wr_en <= wr_en_s;
            done  <= done_s;
            error <= error_s;
            busy  <= (state_s != S_IDLE);
            if (wr_en_s) begin
                wr_addr <= addr_r;
                wr_data <= in_data;
            end
            // Gap counter only runs while a record is open.
            if (accept_s || (state_s == S_IDLE)) begin
                gap_r <= '0;
            end else begin
                gap_r <= gap_r + GAP_W'(1);
            end
            if (accept_s) begin
                case (state_r)
                    S_ADDR_H: addr_h_r <= in_data;
                    S_ADDR_L: addr_r   <= ADDR_WIDTH'({addr_h_r, in_data});
                    S_LEN_H:  len_h_r  <= in_data;
                    S_LEN_L:  rem_r    <= {len_h_r, in_data};
                    S_DATA: begin
                        addr_r <= addr_r + ADDR_WIDTH'(1);
                        rem_r  <= rem_r - 16'd1;
                    end
                    default: begin
                        rem_r <= rem_r;
                    end
                endcase
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Running checksum over every byte after the 0x55 sync byte
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= 8'h00;
        end else if (accept_s) begin
            if (state_r == S_IDLE) begin
                csum_r <= 8'h00;
            end else begin
                csum_r <= csum_add(csum_r, in_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader (TIMEOUT_CYCLES = 16, ADDR_WIDTH = 16).
// A record-level reference model predicts the writes and done/error
// pulses. Build with or without MEM_LOADER_CHECKSUM_EN.
module tb_mem_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [23:0] act_q[$];

    mem_loader #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: collect writes and pulses on the falling edge.
    always @(negedge clk) begin
        if (wr_en) act_q.push_back({wr_addr, wr_data});
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done || error) chk("done_and_error_exclusive", {31'd0, done & error}, 32'd0);
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one framed record and check the model's predicted outcome.
    task automatic run_record(input logic [15:0] addr, input logic [15:0] len,
                              input logic [7:0] seed, input bit bad_cs, input int gap,
                              input bit garbage, input bit exp_done, input bit exp_err);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        logic [7:0] d;
        logic [15:0] a;
        int d0, e0;
        bytes = {8'h55, addr[15:8], addr[7:0], len[15:8], len[7:0]};
        for (int i = 0; i < int'(len); i++) bytes.push_back(8'(seed * (i + 1)));
        sum = 8'h00;
        for (int i = 1; i < bytes.size(); i++) sum = sum + bytes[i];
        if (CSUM_ON) bytes.push_back(bad_cs ? 8'(8'h01 - sum) : 8'(8'h00 - sum));
        act_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        if (garbage) begin
            for (int i = 0; i < 3; i++) begin
                d = 8'($urandom_range(0, 255));
                if (d == 8'h55) d = 8'h56;
                send_byte(d);
                idle(gap);
            end
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i != bytes.size() - 1) idle(gap);
        end
        idle(3);
        chk("write_count", act_q.size(), {16'd0, len});
        for (int i = 0; i < int'(len) && i < act_q.size(); i++) begin
            a = addr + 16'(i);
            d = 8'(seed * (i + 1));
            chk("write_addr_data", {8'd0, act_q[i]}, {8'd0, a, d});
        end
        chk("done_pulses", done_cnt - d0, {31'd0, exp_done});
        chk("error_pulses", err_cnt - e0, {31'd0, exp_err});
        chk("busy_after_record", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic [7:0]  seed;
        bit          bad_cs;
        int          gap;
        bit          garbage;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bc;
        // Wrap record: data 11, 22 at FFFF then 0000; good trailer makes the sum 0.
        vecs[0] = '{16'hFFFF, 16'd2, 8'h11, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        // Same record with a wrong trailer: writes remain, error only with checksum.
        vecs[1] = '{16'hFFFF, 16'd2, 8'h11, 1'b1, 0, 1'b0, !CSUM_ON, CSUM_ON};
        // Garbage then a zero-length record: no writes, one done.
        vecs[2] = '{16'h1000, 16'd0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        // 0x55 inside the payload is plain data.
        vecs[3] = '{16'h0055, 16'd4, 8'h55, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        // Longest legal gap between bytes (one short of the timeout).
        vecs[4] = '{16'h7FFE, 16'd5, 8'h37, 1'b0, TMO - 1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'd1, 8'h80, 1'b1, 2, 1'b1, !CSUM_ON, CSUM_ON};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        idle(2);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_outputs", {8'd0, wr_en, wr_addr, wr_data, busy, done, error}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Cycle-accurate record: 55 02 80 00 03 A9 01 60 [71].
        act_q.delete();
        send_byte(8'h55);
        chk("busy_rises", {31'd0, busy}, 32'd1);
        send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hA9);
        chk("wr0", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'h0280, 8'hA9});
        send_byte(8'h01);
        chk("wr1", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'h0281, 8'h01});
        send_byte(8'h60);
        chk("wr2", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'h0282, 8'h60});
        chk("done_with_last_write", {31'd0, done}, {31'd0, !CSUM_ON});
        chk("busy_with_last_write", {31'd0, busy}, {31'd0, CSUM_ON});
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'h71);
        chk("csum_done", {29'd0, wr_en, done, busy}, 32'b010);
`endif
        idle(1);
        chk("hold_after_record", {6'd0, wr_en, done, wr_addr, wr_data}, {6'd0, 2'b00, 16'h0282, 8'h60});
        chk("busy_low", {31'd0, busy}, 32'd0);

        // Table-driven records.
        foreach (vecs[i])
            run_record(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].bad_cs,
                       vecs[i].gap, vecs[i].garbage, vecs[i].exp_done, vecs[i].exp_err);

        // Timeout: 55 03 00 then silence; error appears TMO edges after the last byte.
        act_q.delete();
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h00);
        idle(TMO - 1);
        chk("no_error_before_timeout", {30'd0, error, busy}, 32'b01);
        idle(1);
        chk("timeout_error", {30'd0, error, busy}, 32'b10);
        idle(1);
        chk("timeout_error_one_cycle", {31'd0, error}, 32'd0);
        chk("timeout_no_writes", act_q.size(), 32'd0);

        // Reset after the second data byte of a 4-byte record.
        act_q.delete();
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h21); send_byte(8'h22);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("outputs_after_mid_reset", {8'd0, wr_en, wr_addr, wr_data, busy, done, error}, 32'd0);
        send_byte(8'h23); send_byte(8'h24);
        idle(3);
        chk("writes_after_mid_reset", act_q.size(), 32'd2);
        run_record(16'h0400, 16'd3, 8'h05, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Randomised records against the model.
        for (int r = 0; r < 20; r++) begin
            bc = CSUM_ON && ($urandom_range(0, 3) == 0);
            run_record(16'($urandom), 16'($urandom_range(0, 8)), 8'($urandom),
                       bc, $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)),
                       !bc, bc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
